// File: rtl/sqg_pkg.sv
// ============================================================================
// Module      : sqg_pkg
// Description : Shared types, width helpers and address packing for the
//               2x2-sum square-pyramid generator (sqg_pyramid).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sqg_pkg;

    // Sequencer states of the pyramid builder
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sqg_state_e;

    // Gap between a level's last read and the next level's first read; it
    // covers the read-data and write-data register stages.
    localparam int DRAIN_CYCLES = 2;

    // Width of a level number able to hold 0..box_idx
    function automatic int lvl_width(input int box_idx);
        return $clog2(box_idx + 1);
    endfunction

    // Full RAM address width: {level, row, col}
    function automatic int addr_width(input int box_idx);
        return lvl_width(box_idx) + 2 * box_idx;
    endfunction

    // Packs {level, row, col}; caller truncates to its address width
    function automatic logic [31:0] pack_addr(input int box_idx, input int lvl,
                                              input int row, input int col);
        return 32'((lvl << (2 * box_idx)) | (row << box_idx) | col);
    endfunction

    // Level count 0 means one level; anything beyond the 1x1 level is cut back
    function automatic int clamp_levels(input int req, input int max_lvl);
        if (req < 1) begin
            return 1;
        end
        if (req > max_lvl) begin
            return max_lvl;
        end
        return req;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sqg_quad_acc.sv
// ============================================================================
// Module      : sqg_quad_acc
// Description : Accumulates the four returned reads of one quad and registers
//               the sum as a RAM write. Optional macro SQG_SAT_EN selects
//               saturating adds; otherwise sums wrap modulo 2^DATA_LEN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sqg_quad_acc #(
    parameter int DATA_LEN = 8,
    parameter int AW       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [DATA_LEN-1:0] in_data,
    input  logic [AW-1:0]       in_addr,
    input  logic                in_last,
    output logic                wr_en,
    output logic [AW-1:0]       wr_addr,
    output logic [DATA_LEN-1:0] wr_data,
    output logic                lvl_done
);

    logic [1:0]          phase_q,    phase_d;
    logic [DATA_LEN-1:0] acc_q,      acc_d;
    logic                wr_en_q,    wr_en_d;
    logic [AW-1:0]       wr_addr_q,  wr_addr_d;
    logic [DATA_LEN-1:0] wr_data_q,  wr_data_d;
    logic                lvl_done_q, lvl_done_d;
    logic [DATA_LEN-1:0] acc_sum;

    function automatic logic [DATA_LEN-1:0] add_cell(input logic [DATA_LEN-1:0] a,
                                                     input logic [DATA_LEN-1:0] b);
`ifdef SQG_SAT_EN
        logic [DATA_LEN:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DATA_LEN] ? {DATA_LEN{1'b1}} : s[DATA_LEN-1:0];
`else
        return a + b;
`endif
    endfunction

    assign acc_sum = add_cell(acc_q, in_data);

    // Phase 0 loads, phases 1-3 add; phase 3 launches the write
    always_comb begin
        phase_d    = phase_q;
        acc_d      = acc_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        lvl_done_d = 1'b0;
        if (in_valid) begin
            phase_d = phase_q + 2'd1;
            acc_d   = (phase_q == 2'd0) ? in_data : acc_sum;
            if (phase_q == 2'd3) begin
                wr_en_d    = 1'b1;
                wr_addr_d  = in_addr;
                wr_data_d  = acc_sum;
                lvl_done_d = in_last;
            end
        end
    end

    // Accumulator and write-stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= 2'd0;
            acc_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            lvl_done_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            acc_q      <= acc_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            lvl_done_q <= lvl_done_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign lvl_done = lvl_done_q;

endmodule

`default_nettype wire

// File: rtl/sqg_pyramid.sv
// ============================================================================
// Module      : sqg_pyramid
// Description : Builds the 2x2-sum pyramid over a 2^BOX_IDX square level 0 in
//               the box-count RAM, level by level, with start/busy/done.
//               Optional macro SQG_SAT_EN: saturating sums (see sqg_quad_acc).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sqg_pyramid
    import sqg_pkg::*;
#(
    parameter int BOX_IDX  = 3,
    parameter int DATA_LEN = 8,
    parameter int LVL_W    = lvl_width(BOX_IDX),
    parameter int AW       = addr_width(BOX_IDX)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LVL_W-1:0]    cfg_levels,
    output logic                busy,
    output logic                done,
    output logic                lvl_done,
    output logic [LVL_W-1:0]    lvl_idx,
    output logic                rd_en,
    output logic [AW-1:0]       rd_addr,
    input  logic [DATA_LEN-1:0] rd_data,
    output logic                wr_en,
    output logic [AW-1:0]       wr_addr,
    output logic [DATA_LEN-1:0] wr_data
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    sqg_state_e         state_q,   state_d;
    logic [LVL_W-1:0]   lvl_idx_q, lvl_idx_d;
    logic [LVL_W-1:0]   lvl_max_q, lvl_max_d;
    logic [BOX_IDX-1:0] row_q,     row_d;
    logic [BOX_IDX-1:0] col_q,     col_d;
    logic [1:0]         rphase_q,  rphase_d;
    logic [DRAIN_W-1:0] drain_q,   drain_d;
    logic               rvalid_q,  rvalid_d;
    logic [AW-1:0]      dest_q,    dest_d;
    logic               last_q,    last_d;

    logic [BOX_IDX-1:0] side_m1;
    logic               last_quad;
    logic [BOX_IDX-1:0] rd_row;
    logic [BOX_IDX-1:0] rd_col;

    // Output side of level L is 2^(BOX_IDX-L); r and c stay below half the
    // source side, so 2r+p1 / 2c+p0 are a shift with the phase bit appended.
    assign side_m1   = {BOX_IDX{1'b1}} >> lvl_idx_q;
    assign last_quad = (row_q == side_m1) && (col_q == side_m1);
    assign rd_row    = {row_q[BOX_IDX-2:0], rphase_q[1]};
    assign rd_col    = {col_q[BOX_IDX-2:0], rphase_q[0]};

    assign rd_en   = (state_q == ST_READ);
    assign rd_addr = rd_en ? AW'(pack_addr(BOX_IDX, int'(lvl_idx_q) - 1,
                                           int'(rd_row), int'(rd_col))) : '0;

    // Read-side context that travels with the data returned next cycle
    assign rvalid_d = rd_en;
    assign dest_d   = AW'(pack_addr(BOX_IDX, int'(lvl_idx_q), int'(row_q), int'(col_q)));
    assign last_d   = rd_en && (rphase_q == 2'd3) && last_quad;

    // Next-state: quad/raster address walk, drain gap and level stepping
    always_comb begin
        state_d   = state_q;
        lvl_idx_d = lvl_idx_q;
        lvl_max_d = lvl_max_q;
        row_d     = row_q;
        col_d     = col_q;
        rphase_d  = rphase_q;
        drain_d   = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lvl_max_d = LVL_W'(clamp_levels(int'(cfg_levels), BOX_IDX));
                    lvl_idx_d = LVL_W'(1);
                    row_d     = '0;
                    col_d     = '0;
                    rphase_d  = 2'd0;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                rphase_d = rphase_q + 2'd1;
                if (rphase_q == 2'd3) begin
                    if (col_q == side_m1) begin
                        col_d = '0;
                        if (row_q == side_m1) begin
                            row_d   = '0;
                            drain_d = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            row_d = row_q + BOX_IDX'(1);
                        end
                    end else begin
                        col_d = col_q + BOX_IDX'(1);
                    end
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q + DRAIN_W'(1);
                if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    if (lvl_idx_q == lvl_max_q) begin
                        state_d = ST_DONE;
                    end else begin
                        lvl_idx_d = lvl_idx_q + LVL_W'(1);
                        state_d   = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer and read-pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lvl_idx_q <= '0;
            lvl_max_q <= '0;
            row_q     <= '0;
            col_q     <= '0;
            rphase_q  <= 2'd0;
            drain_q   <= '0;
            rvalid_q  <= 1'b0;
            dest_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lvl_idx_q <= lvl_idx_d;
            lvl_max_q <= lvl_max_d;
            row_q     <= row_d;
            col_q     <= col_d;
            rphase_q  <= rphase_d;
            drain_q   <= drain_d;
            rvalid_q  <= rvalid_d;
            dest_q    <= dest_d;
            last_q    <= last_d;
        end
    end

    assign busy    = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done    = (state_q == ST_DONE);
    assign lvl_idx = lvl_idx_q;

    sqg_quad_acc #(
        .DATA_LEN (DATA_LEN),
        .AW       (AW)
    ) u_quad_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (rvalid_q),
        .in_data  (rd_data),
        .in_addr  (dest_q),
        .in_last  (last_q),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .lvl_done (lvl_done)
    );

endmodule

`default_nettype wire

// File: tb/tb_sqg_pyramid.sv
// ============================================================================
// Module      : tb_sqg_pyramid
// Description : Self-checking bench for sqg_pyramid (BOX_IDX=3, DATA_LEN=8)
//               with a RAM model, a pyramid/timeline reference and literal
//               anchors. Honors SQG_SAT_EN for the expected sums.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sqg_pyramid;

    localparam int BOX = 3;
    localparam int DL  = 8;
    localparam int LW  = 2;
    localparam int AWB = 8;
    localparam int CMAX = 128;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [LW-1:0]  cfg_levels;
    logic           busy, done, lvl_done, rd_en, wr_en;
    logic [LW-1:0]  lvl_idx;
    logic [AWB-1:0] rd_addr, wr_addr;
    logic [DL-1:0]  rd_data, wr_data;

    sqg_pyramid #(.BOX_IDX(BOX), .DATA_LEN(DL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_levels(cfg_levels),
        .busy(busy), .done(done), .lvl_done(lvl_done), .lvl_idx(lvl_idx),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    // RAM: level 0 image kept separately, upper levels written by the DUT
    logic [DL-1:0] l0  [0:63];
    logic [DL-1:0] mem [0:255];
    always @(posedge clk) begin
        if (rd_en) rd_data <= (rd_addr[7:6] == 2'd0) ? l0[rd_addr[5:0]] : mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference pyramid and per-cycle expected timeline
    int pyr [0:3][0:7][0:7];
    int e_busy[0:CMAX-1], e_done[0:CMAX-1], e_ldone[0:CMAX-1], e_lvl[0:CMAX-1];
    int e_rd_en[0:CMAX-1], e_rd_addr[0:CMAX-1];
    int e_wr_en[0:CMAX-1], e_wr_addr[0:CMAX-1], e_wr_data[0:CMAX-1];
    int done_c;

    function automatic int add8(input int a, input int b);
`ifdef SQG_SAT_EN
        return (a + b > 255) ? 255 : a + b;
`else
        return (a + b) % 256;
`endif
    endfunction

    task automatic load_pattern(input int pat);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int v;
                case (pat)
                    0:       v = 1;
                    1:       v = r * 8 + c;
                    2:       v = 255;
                    default: v = int'($urandom_range(0, 255));
                endcase
                pyr[0][r][c] = v;
                l0[r * 8 + c] = DL'(v);
            end
        end
    endtask

    task automatic build_exp(input int nlev);
        int b, s, n, r, c, t, w;
        for (int i = 0; i < CMAX; i++) begin
            e_busy[i] = 0; e_done[i] = 0; e_ldone[i] = 0; e_lvl[i] = 0;
            e_rd_en[i] = 0; e_rd_addr[i] = 0;
            e_wr_en[i] = 0; e_wr_addr[i] = 0; e_wr_data[i] = 0;
        end
        for (int l = 1; l <= 3; l++) begin
            s = 8 >> l;
            for (int rr = 0; rr < s; rr++)
                for (int cc = 0; cc < s; cc++)
                    pyr[l][rr][cc] = add8(add8(add8(pyr[l-1][2*rr][2*cc],
                                     pyr[l-1][2*rr][2*cc+1]), pyr[l-1][2*rr+1][2*cc]),
                                     pyr[l-1][2*rr+1][2*cc+1]);
        end
        b = 1;
        for (int l = 1; l <= nlev; l++) begin
            s = 8 >> l;
            n = s * s;
            for (int q = 0; q < n; q++) begin
                r = q / s;
                c = q % s;
                for (int p = 0; p < 4; p++) begin
                    t = b + 4 * q + p;
                    e_rd_en[t]   = 1;
                    e_rd_addr[t] = ((l - 1) << 6) | ((2 * r + p / 2) << 3) | (2 * c + p % 2);
                end
                w = b + 4 * q + 5;
                e_wr_en[w]   = 1;
                e_wr_addr[w] = (l << 6) | (r << 3) | c;
                e_wr_data[w] = pyr[l][r][c];
                e_ldone[w]   = (q == n - 1) ? 1 : 0;
            end
            for (int k = b; k <= b + 4 * n + 1; k++) begin
                e_busy[k] = 1;
                e_lvl[k]  = l;
            end
            b = b + 4 * n + 2;
        end
        done_c = b;
        e_done[b] = 1;
    endtask

    // Cycle-by-cycle compare against the timeline
    bit chk_on = 1'b0;
    int rel = 0;
    int first_wr = -1, first_addr = -1, first_data = -1, done_rel = -1;

    always @(negedge clk) begin
        if (chk_on && rel <= done_c + 2) begin
            check($sformatf("busy@%0d", rel), int'(busy), e_busy[rel]);
            check($sformatf("done@%0d", rel), int'(done), e_done[rel]);
            check($sformatf("lvl_done@%0d", rel), int'(lvl_done), e_ldone[rel]);
            check($sformatf("rd_en@%0d", rel), int'(rd_en), e_rd_en[rel]);
            check($sformatf("wr_en@%0d", rel), int'(wr_en), e_wr_en[rel]);
            if (e_rd_en[rel] != 0)
                check($sformatf("rd_addr@%0d", rel), int'(rd_addr), e_rd_addr[rel]);
            if (e_wr_en[rel] != 0) begin
                check($sformatf("wr_addr@%0d", rel), int'(wr_addr), e_wr_addr[rel]);
                check($sformatf("wr_data@%0d", rel), int'(wr_data), e_wr_data[rel]);
            end
            if (e_busy[rel] != 0)
                check($sformatf("lvl_idx@%0d", rel), int'(lvl_idx), e_lvl[rel]);
            if (wr_en === 1'b1 && first_wr < 0) begin
                first_wr   = rel;
                first_addr = int'(wr_addr);
                first_data = int'(wr_data);
            end
            if (done === 1'b1 && done_rel < 0) done_rel = rel;
            rel++;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " lvl_done"}, int'(lvl_done), 0);
        check({tag, " lvl_idx"}, int'(lvl_idx), 0);
        check({tag, " rd_en"}, int'(rd_en), 0);
        check({tag, " rd_addr"}, int'(rd_addr), 0);
        check({tag, " wr_en"}, int'(wr_en), 0);
        check({tag, " wr_addr"}, int'(wr_addr), 0);
        check({tag, " wr_data"}, int'(wr_data), 0);
    endtask

    task automatic run(input logic [LW-1:0] cfg, input int nexp, input bit spur,
                       input int abort_at);
        build_exp(nexp);
        first_wr = -1; first_addr = -1; first_data = -1; done_rel = -1;
        @(posedge clk); #1;
        start = 1'b1;
        cfg_levels = cfg;
        rel = 0;
        chk_on = 1'b1;
        for (int k = 1; k <= done_c + 3; k++) begin
            @(posedge clk); #1;
            start = spur && (k == 20);
            if (k == 1 || k == 20) cfg_levels = cfg ^ 2'b10;
            if (k == abort_at) begin
                chk_on = 1'b0;
                rst_n = 1'b0;
                #1;
                check_zero("abort");
                @(posedge clk); #1;
                rst_n = 1'b1;
                break;
            end
        end
        chk_on = 1'b0;
    endtask

    task automatic verify_ram(input int nlev, input string tag);
        for (int l = 1; l <= nlev; l++)
            for (int r = 0; r < (8 >> l); r++)
                for (int c = 0; c < (8 >> l); c++)
                    check($sformatf("%s ram L%0d(%0d,%0d)", tag, l, r, c),
                          int'(mem[(l << 6) | (r << 3) | c]), pyr[l][r][c]);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        cfg_levels = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // All ones, three levels
        load_pattern(0);
        run(2'd3, 3, 1'b0, 0);
        verify_ram(3, "ones");
        check("ones L1 literal", int'(mem[8'd64]), 4);
        check("ones L2 literal", int'(mem[8'd128]), 16);
        check("ones L3 literal", int'(mem[8'd192]), 64);
        check("ones done cycle", done_rel, 91);

        // Ramp, one level
        load_pattern(1);
        run(2'd1, 1, 1'b0, 0);
        verify_ram(1, "ramp");
        check("ramp first wr cycle", first_wr, 6);
        check("ramp first wr addr", first_addr, 64);
        check("ramp first wr data", first_data, 18);
        check("ramp cell(0,1) literal", int'(mem[8'd65]), 26);
        check("ramp done cycle", done_rel, 67);

        // Full-scale cells: saturate or wrap
        load_pattern(2);
        run(2'd1, 1, 1'b0, 0);
`ifdef SQG_SAT_EN
        check("ff literal", int'(mem[8'd64]), 255);
`else
        check("ff literal", int'(mem[8'd64]), 252);
`endif

        // Level-count clamping on random data
        load_pattern(3);
        run(2'd0, 1, 1'b0, 0);
        check("cfg0 done cycle", done_rel, 67);
        verify_ram(1, "cfg0");
        run(2'(7), 3, 1'b0, 0);
        check("cfg7 done cycle", done_rel, 91);
        verify_ram(3, "cfg7");

        // Start while busy is ignored
        load_pattern(1);
        run(2'd3, 3, 1'b1, 0);
        check("spur done cycle", done_rel, 91);
        verify_ram(3, "spur");

        // Abort at cycle 40, then a fresh full run
        load_pattern(2);
        run(2'd3, 3, 1'b0, 40);
        load_pattern(0);
        run(2'd3, 3, 1'b0, 0);
        check("fresh done cycle", done_rel, 91);
        verify_ram(3, "fresh");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
